stage_2_id_bypass: RTL
======================

// Module: stage_2_id_bypass
// PURPOSE
//  Decode stage (ID) of the 5-stage LA32R pipeline, successor to the stall-only ID.
//  Decodes 20 insts (add.w sub.w slt sltu nor and or xor slli.w srli.w srai.w addi.w ld.w st.w
//  jirl b bl beq bne lu12i.w), reads the GPR file, and resolves branches in ID.
//  Adds a parametrised N-stage bypass network and a load-use interlock.
//  Sits between IF (stage 1) and EX (stage 3).
// PARAMETERS
//  FWD_STAGES  3  number of downstream producer stages; index 0 = youngest (EX). Legal 1..4.
// PORTS
//  clk                input   1              clock
//  reset              input   1              synchronous, active-high reset
//  valid_1            input   1              IF payload valid
//  allow_2            output  1              ID can accept this cycle
//  valid_2            output  1              ID payload valid toward EX
//  allow_3            input   1              EX can accept
//  stage_1_to_2       input   64             {inst[31:0], pc[31:0]}
//  br_taken           output  1              redirect IF; one-cycle pulse per branch
//  br_target          output  32             redirect PC
//  stage_2_to_3       output  117            {rf_we,dest[4:0],res_from_mem,src1[31:0],src2[31:0],alu_op[11:0],mem_we,mem_en,pc[31:0]}
//  memory_write_data  output  32             st.w data (bypassed rd value)
//  rf_raddr1          output  5              GPR read port 1 = rj
//  rf_raddr2          output  5              GPR read port 2 = rd (st.w/beq/bne) else rk
//  rf_rdata1          input   32             GPR data port 1
//  rf_rdata2          input   32             GPR data port 2
//  fwd_we             input   FWD_STAGES     stage i valid AND writes GPR
//  fwd_waddr          input   5*FWD_STAGES   dest of stage i, slice [5i+4:5i]
//  fwd_wdata          input   32*FWD_STAGES  result of stage i, slice [32i+31:32i]
//  fwd_data_ok        input   FWD_STAGES     stage i result available this cycle (0 = load in flight)
// BEHAVIOUR
//  - Reset: valid_r=0, payload reg=0; hence valid_2=0, br_taken=0, allow_2=1. Reset dominates all.
//  - ready_go = ~stall; allow_2 = ~valid_r | (ready_go & allow_3); valid_2 = valid_r & ready_go.
//  - On allow_2: payload <= stage_1_to_2; valid_r <= valid_1 & ~br_taken (inst fetched in the
//    branch-resolve cycle is squashed). allow_2=0: payload and valid_r hold.
//  - Latency: 1 cycle IF->ID register; decode/read/bypass/branch combinational from ID register.
//  - Read enables: rj_re = ~(lu12i.w|b|bl); rkd_re = ~src2_is_imm | st.w. Address 0 never matches.
//  - Bypass per port: scan i=0..N-1, first i with fwd_we[i] & addr match wins (youngest first);
//    no hit -> rf_rdata. Hit with fwd_data_ok[i]=0 -> stall (load-use). Older hits are masked.
//  - stall = valid_r & ((rj_re & port1_stall) | (rkd_re & port2_stall)).
//  - br_taken = valid_r & ready_go & allow_3 & (b|bl|jirl|beq&eq|bne&~eq); eq uses bypassed values.
//    Stalled or EX-blocked branch never pulses; pulse is exactly one cycle per branch.
//  - br_target: pc+sext(offs26<<2) for b/bl; pc+sext(offs16<<2) for beq/bne; rj+sext(offs16<<2) jirl.
//  - src1 = pc for jirl/bl else rj; src2 = 4 for jirl/bl, {si20,12'b0} for lu12i.w, sext(si12)/ui5
//    for imm ops, else rkd. dest = 1 for bl else rd. All arithmetic 32-bit, wraps modulo 2^32.
//  - Undefined encodings: rf_we=0, mem_we=0, mem_en=0, alu_op=0, no branch; still flow as bubbles.
//  - rf_we=0 for st.w, beq, bne, b; mem_en = ld.w | st.w; res_from_mem = ld.w.
// CONFIGURATION
//  ID_BYPASS_EN defined: bypass as above; stall only on hits with fwd_data_ok=0.
//  ID_BYPASS_EN undefined: fwd_wdata/fwd_data_ok ignored; any enabled-port hit stalls until
//   the producer retires (stall-only interlock); operands always from rf_rdata.
// TESTING
//  1 reset high 2 cycles, valid_1=1 -> valid_2=0, br_taken=0, allow_2=1 throughout.
//  2 add.w r3,r1,r2 with fwd_we[0]=1,waddr=1,wdata=0x10,ok=1; rf_rdata2=0x5 -> src1=0x10,src2=0x5, no stall.
//  3 ld.w r4 in EX (waddr=4,ok=0), next add.w r5,r4,r4 -> valid_2=0, allow_2=0 1 cycle; when ok=1 in MEM, wdata=0x77 forwarded, valid_2=1.
//  4 fwd[0] waddr=6 wdata=0xA, fwd[2] waddr=6 wdata=0xB; read r6 -> 0xA (youngest wins); read r0 with waddr=0 hits -> rf value 0.
//  5 beq pc=0x1c000010 offs16=4, rj=rd=0x3 via bypass, allow_3=1 -> br_taken 1 cycle, target 0x1c000020; next IF inst squashed (valid_2=0 next cycle).
//  6 jirl pending with allow_3=0 for 3 cycles -> br_taken stays 0, payload held; allow_3=1 -> single pulse, target=rj+offs; ID_BYPASS_EN off: test 2 stalls until fwd_we[*]=0.

Source files
------------

// File: rtl/stage_2_id_bypass.sv
// Decode stage of the 5-stage LA32R pipeline: decode, GPR read, branch resolve, N-stage bypass and load-use interlock.
// Define ID_BYPASS_EN to forward producer results; otherwise any producer hit stalls until that producer retires.
module stage_2_id_bypass #(
    parameter int FWD_STAGES = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_1,
    output logic                     allow_2,
    output logic                     valid_2,
    input  logic                     allow_3,
    input  logic [63:0]              stage_1_to_2,
    output logic                     br_taken,
    output logic [31:0]              br_target,
    output logic [116:0]             stage_2_to_3,
    output logic [31:0]              memory_write_data,
    output logic [4:0]               rf_raddr1,
    output logic [4:0]               rf_raddr2,
    input  logic [31:0]              rf_rdata1,
    input  logic [31:0]              rf_rdata2,
    input  logic [FWD_STAGES-1:0]    fwd_we,
    input  logic [5*FWD_STAGES-1:0]  fwd_waddr,
    input  logic [32*FWD_STAGES-1:0] fwd_wdata,
    input  logic [FWD_STAGES-1:0]    fwd_data_ok
);

    logic        vld_p1;
    logic [63:0] payload_p1;

    // IF -> ID register
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            payload_p1 <= '0;
        end else if (allow_2) begin
            vld_p1     <= valid_1 & ~br_taken;
            payload_p1 <= stage_1_to_2;
        end
    end

    logic [31:0] inst, pc;
    logic [16:0] op17;
    logic [9:0]  op10;
    logic [6:0]  op7;
    logic [5:0]  op6;
    logic [4:0]  rd, rj, rk;

    assign inst = payload_p1[63:32];
    assign pc   = payload_p1[31:0];
    assign op17 = inst[31:15];
    assign op10 = inst[31:22];
    assign op7  = inst[31:25];
    assign op6  = inst[31:26];
    assign rd   = inst[4:0];
    assign rj   = inst[9:5];
    assign rk   = inst[14:10];

    logic inst_add, inst_sub, inst_slt, inst_sltu, inst_nor, inst_and, inst_or, inst_xor;
    logic inst_slli, inst_srli, inst_srai, inst_addi, inst_ld, inst_st;
    logic inst_jirl, inst_b, inst_bl, inst_beq, inst_bne, inst_lu12i, inst_known;

    assign inst_add   = op17 == 17'h00020;
    assign inst_sub   = op17 == 17'h00022;
    assign inst_slt   = op17 == 17'h00024;
    assign inst_sltu  = op17 == 17'h00025;
    assign inst_nor   = op17 == 17'h00028;
    assign inst_and   = op17 == 17'h00029;
    assign inst_or    = op17 == 17'h0002a;
    assign inst_xor   = op17 == 17'h0002b;
    assign inst_slli  = op17 == 17'h00081;
    assign inst_srli  = op17 == 17'h00089;
    assign inst_srai  = op17 == 17'h00091;
    assign inst_addi  = op10 == 10'h00a;
    assign inst_ld    = op10 == 10'h0a2;
    assign inst_st    = op10 == 10'h0a6;
    assign inst_jirl  = op6  == 6'h13;
    assign inst_b     = op6  == 6'h14;
    assign inst_bl    = op6  == 6'h15;
    assign inst_beq   = op6  == 6'h16;
    assign inst_bne   = op6  == 6'h17;
    assign inst_lu12i = op7  == 7'h0a;

    assign inst_known = inst_add | inst_sub | inst_slt | inst_sltu | inst_nor | inst_and
                      | inst_or | inst_xor | inst_slli | inst_srli | inst_srai | inst_addi
                      | inst_ld | inst_st | inst_jirl | inst_b | inst_bl | inst_beq
                      | inst_bne | inst_lu12i;

    logic src2_is_imm, rj_re, rkd_re;
    assign src2_is_imm = inst_slli | inst_srli | inst_srai | inst_addi | inst_ld | inst_st
                       | inst_lu12i | inst_jirl | inst_b | inst_bl;
    assign rj_re  = ~(inst_lu12i | inst_b | inst_bl);
    assign rkd_re = ~src2_is_imm | inst_st;

    assign rf_raddr1 = rj;
    assign rf_raddr2 = (inst_st | inst_beq | inst_bne) ? rd : rk;

    // Scan oldest to youngest so the youngest matching producer overrides the rest.
    logic        hit1, hit2, ok1, ok2;
    logic [31:0] fwd1, fwd2;
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        ok1  = 1'b1;
        ok2  = 1'b1;
        fwd1 = rf_rdata1;
        fwd2 = rf_rdata2;
        for (int i = FWD_STAGES - 1; i >= 0; i--) begin
            if (fwd_we[i] && rf_raddr1 != 5'd0 && fwd_waddr[5*i +: 5] == rf_raddr1) begin
                hit1 = 1'b1;
                ok1  = fwd_data_ok[i];
                fwd1 = fwd_wdata[32*i +: 32];
            end
            if (fwd_we[i] && rf_raddr2 != 5'd0 && fwd_waddr[5*i +: 5] == rf_raddr2) begin
                hit2 = 1'b1;
                ok2  = fwd_data_ok[i];
                fwd2 = fwd_wdata[32*i +: 32];
            end
        end
    end

    logic [31:0] rj_val, rkd_val;
    logic        port1_stall, port2_stall;
`ifdef ID_BYPASS_EN
    assign rj_val      = fwd1;
    assign rkd_val     = fwd2;
    assign port1_stall = hit1 & ~ok1;
    assign port2_stall = hit2 & ~ok2;
`else
    logic unused_fwd;
    assign rj_val      = rf_rdata1;
    assign rkd_val     = rf_rdata2;
    assign port1_stall = hit1;
    assign port2_stall = hit2;
    assign unused_fwd  = ^{fwd1, fwd2, ok1, ok2};
`endif

    logic stall, ready_go, rj_eq_rd, br_cond;
    assign stall    = vld_p1 & ((rj_re & port1_stall) | (rkd_re & port2_stall));
    assign ready_go = ~stall;
    assign allow_2  = ~vld_p1 | (ready_go & allow_3);
    assign valid_2  = vld_p1 & ready_go;

    assign rj_eq_rd = rj_val == rkd_val;
    assign br_cond  = inst_b | inst_bl | inst_jirl | (inst_beq & rj_eq_rd) | (inst_bne & ~rj_eq_rd);
    assign br_taken = vld_p1 & ready_go & allow_3 & br_cond;

    logic signed [31:0] si12_sx, offs16_sx, offs26_sx, br_offs;
    assign si12_sx   = {{20{inst[21]}}, inst[21:10]};
    assign offs16_sx = {{14{inst[25]}}, inst[25:10], 2'b00};
    assign offs26_sx = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
    assign br_offs   = (inst_b | inst_bl) ? offs26_sx : offs16_sx;
    assign br_target = (inst_jirl ? rj_val : pc) + $unsigned(br_offs);

    // Branches without a link write nothing and carry no ALU operation into EX.
    logic [11:0] alu_op;
    assign alu_op = {inst_lu12i, inst_srai, inst_srli, inst_slli, inst_xor, inst_or, inst_nor,
                     inst_and, inst_sltu, inst_slt, inst_sub,
                     inst_add | inst_addi | inst_ld | inst_st | inst_jirl | inst_bl};

    logic [31:0] src1, src2;
    logic [4:0]  dest;
    logic        rf_we, mem_we, mem_en, res_from_mem;

    assign src1 = (inst_jirl | inst_bl) ? pc : rj_val;
    always_comb begin
        src2 = rkd_val;
        if (inst_jirl | inst_bl)                     src2 = 32'd4;
        else if (inst_lu12i)                         src2 = {inst[24:5], 12'b0};
        else if (inst_slli | inst_srli | inst_srai)  src2 = {27'b0, inst[14:10]};
        else if (inst_addi | inst_ld | inst_st)      src2 = $unsigned(si12_sx);
    end

    assign dest         = inst_bl ? 5'd1 : rd;
    assign rf_we        = inst_known & ~(inst_st | inst_beq | inst_bne | inst_b);
    assign mem_we       = inst_st;
    assign mem_en       = inst_ld | inst_st;
    assign res_from_mem = inst_ld;

    assign stage_2_to_3      = {rf_we, dest, res_from_mem, src1, src2, alu_op, mem_we, mem_en, pc};
    assign memory_write_data = rkd_val;

endmodule
